// File: rtl/imem_boot_ctrl_pkg.sv
// rtl/imem_boot_ctrl_pkg.sv - shared state encodings and sizing helpers for the imem boot loader
package imem_boot_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HDR0  = 3'd0;
    localparam state_t ST_HDR1  = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_ERR   = 3'd5;

    localparam int WORD_BYTES = 4;
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    function automatic int depth_words(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// rtl/boot_word_asm.sv - packs four stream bytes into one little-endian 32-bit word
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          synchronous restart of the byte counter and shift register
//   push         accept rx_byte this cycle
//   rx_byte      incoming stream byte
//   word         word as it stands once rx_byte is included (valid when word_full & push)
//   word_full    the byte being pushed is the fourth of the word
module boot_word_asm
    import imem_boot_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  rx_byte,
    output logic [31:0] word,
    output logic        word_full
);

    logic [BCNT_W-1:0] cnt;
    logic [23:0]       sreg;

    // Only the three earlier bytes are stored; the fourth is taken straight
    // from the input so the top can latch the complete word on that edge.
    assign word      = {rx_byte, sreg};
    assign word_full = (cnt == BCNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (clr) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (push) begin
            cnt  <= cnt + 1'b1;
            sreg <= {rx_byte, sreg[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - loads a byte-stream program image into imem, then releases the core
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready byte stream in; transfer on rx_valid & rx_ready
//   reboot                   restart pulse, honoured in DONE or ERR only
//   imem_we/imem_addr/imem_wdata  one-cycle instruction memory write
//   core_rst                 active-low core reset (1 = core running)
//   boot_done, boot_err      status levels
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reboot,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              boot_done,
    output logic              boot_err
);

    localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(depth_words(ADDR_W));

    state_t            state;
    logic [7:0]        n_lo;
    logic [CNT_W-1:0]  n_cnt;
    logic [ADDR_W:0]   index;    // one extra bit so index can reach DEPTH

    logic              transfer;
    logic              restart;
    logic [CNT_W-1:0]  n_hdr;
    logic [CNT_W-1:0]  index_inc;
    logic [31:0]       asm_word;
    logic              asm_full;

    // State resets to HDR0, so rx_ready is gated by rst to stay low during reset.
    assign rx_ready  = rst && (state == ST_HDR0 || state == ST_HDR1 || state == ST_DATA);
    assign transfer  = rx_valid && rx_ready;
    assign restart   = reboot && (state == ST_DONE || state == ST_ERR);
    assign n_hdr     = CNT_W'({rx_data, n_lo});
    assign index_inc = CNT_W'(index) + CNT_W'(1);

    boot_word_asm u_word_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (restart),
        .push      (transfer && state == ST_DATA),
        .rx_byte   (rx_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_HDR0;
            n_lo       <= '0;
            n_cnt      <= '0;
            index      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_HDR0: begin
                    if (transfer) begin
                        n_lo  <= rx_data;
                        state <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (transfer) begin
                        n_cnt <= n_hdr;
                        if (n_hdr == '0) begin
                            state     <= ST_DONE;
                            core_rst  <= 1'b1;
                            boot_done <= 1'b1;
                        end else if (n_hdr > DEPTH_N) begin
                            state    <= ST_ERR;
                            boot_err <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (transfer && asm_full) begin
                        state      <= ST_WRITE;
                        imem_we    <= 1'b1;
                        imem_addr  <= index[ADDR_W-1:0];
                        imem_wdata <= asm_word;
                    end
                end
                ST_WRITE: begin
                    index <= index + 1'b1;
                    if (index_inc == n_cnt) begin
                        state     <= ST_DONE;
                        core_rst  <= 1'b1;
                        boot_done <= 1'b1;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (restart) begin
                        state     <= ST_HDR0;
                        index     <= '0;
                        core_rst  <= 1'b0;
                        boot_done <= 1'b0;
                        boot_err  <= 1'b0;
                    end
                end
                default: state <= ST_HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - randomized self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              reboot;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              boot_done;
    logic              boot_err;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reboot     (reboot),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem_we lasts one cycle, so each write is seen at exactly one negedge.
    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (t == 1000) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Streams the image for 'words' and checks the writes and release against
    // the image itself: word i must appear at address i, once, in order.
    task automatic run_load(input logic [31:0] words[$], input int max_gap, input string tag);
        int n;
        n = words.size();
        log_addr.delete();
        log_data.delete();
        send_byte(8'(n), max_gap);
        send_byte(8'(n >> 8), max_gap);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) send_byte(8'(words[i] >> (8 * k)), max_gap);
        end
        if (n > 0) begin
            @(negedge clk);
            check({tag, "_we_last"}, {63'd0, imem_we}, 64'd1);
            check({tag, "_core_rst_held"}, {63'd0, core_rst}, 64'd0);
        end
        @(negedge clk);
        check({tag, "_core_rst"}, {63'd0, core_rst}, 64'd1);
        check({tag, "_boot_done"}, {63'd0, boot_done}, 64'd1);
        check({tag, "_rx_ready_done"}, {63'd0, rx_ready}, 64'd0);
        check({tag, "_nwrites"}, 64'(log_addr.size()), 64'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(log_addr[i]), 64'(i));
            check({tag, "_data"}, 64'(log_data[i]), 64'(words[i]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reboot(input string tag);
        reboot = 1'b1;
        @(posedge clk);
        #1;
        reboot = 1'b0;
        check({tag, "_core_rst_clr"}, {63'd0, core_rst}, 64'd0);
        check({tag, "_done_clr"}, {63'd0, boot_done}, 64'd0);
        check({tag, "_err_clr"}, {63'd0, boot_err}, 64'd0);
        check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, {63'd0, core_rst}, 64'd0);
        check({tag, "_we"}, {63'd0, imem_we}, 64'd0);
        check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
        check({tag, "_done"}, {63'd0, boot_done}, 64'd0);
        check({tag, "_err"}, {63'd0, boot_err}, 64'd0);
        check({tag, "_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    endtask

    initial begin
        logic [31:0] img[$];
        int n;

        rst      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        reboot   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset_release_rx_ready", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;

        img = '{32'h00500513, 32'h00700593};
        run_load(img, 0, "two_word");
        do_reboot("reboot_done");

        img.delete();
        run_load(img, 0, "empty");
        do_reboot("reboot_empty");

        // Oversize header: 257 words does not fit a 256-word imem.
        log_addr.delete();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("oversize_err", {63'd0, boot_err}, 64'd1);
        check("oversize_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("oversize_core_rst", {63'd0, core_rst}, 64'd0);
        check("oversize_nwrites", 64'(log_addr.size()), 64'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        do_reboot("reboot_err");

        for (int r = 0; r < 5; r++) begin
            img.delete();
            n = $urandom_range(20, 1);
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_load(img, 3, "random");
            do_reboot("reboot_random");
        end

        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        run_load(img, 0, "full_depth");
        do_reboot("reboot_full");

        // Abort after header plus one word, then reload from scratch.
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst = 1'b1;
        img.delete();
        img = '{$urandom, $urandom};
        run_load(img, 2, "reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
